// File: rtl/if_prefetch_queue.sv
// Instruction prefetch FIFO owning the fetch PC; head entry visible 1 cycle after its fetch edge.
// Stall holds the head while fetch fills free slots; redirect flushes the queue and reloads the PC.
module if_prefetch_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 10
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall,
  input  logic                       redirect,
  input  logic [ADDR_W-1:0]          redirect_addr,
  output logic [ADDR_W-1:0]          imem_addr,
  input  logic [31:0]                imem_data,
  output logic                       out_valid,
  output logic [ADDR_W-1:0]          out_pc_plus4,
  output logic [31:0]                out_instr,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0]  FULL_CNT   = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

  typedef struct packed {
    logic [ADDR_W-1:0] pc_plus4;
    logic [31:0]       instr;
  } entry_t;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  entry_t            mem_q [DEPTH];
  entry_t            mem_d [DEPTH];

  logic              pop;
  logic              push;
  logic [ADDR_W-1:0] pc_plus4;

  assign pc_plus4 = pc_q + ADDR_W'(4);
  assign out_valid = (count_q != '0);
  assign pop  = out_valid & ~stall;
  // A full queue may still accept a fetch when the head leaves in the same cycle.
  assign push = ~redirect & ((count_q < FULL_CNT) | pop);

  always_comb begin
    pc_d     = pc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;

    if (redirect) begin
      pc_d     = redirect_addr & ALIGN_MASK;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = '{pc_plus4: pc_plus4, instr: imem_data};
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        pc_d            = pc_plus4;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign imem_addr    = pc_q;
  assign count        = count_q;
  assign out_pc_plus4 = out_valid ? mem_q[rd_ptr_q].pc_plus4 : '0;
  assign out_instr    = out_valid ? mem_q[rd_ptr_q].instr    : '0;

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Directed bench for if_prefetch_queue with a combinational ROM model.
module tb_if_prefetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [9:0]  redirect_addr;
  logic [9:0]  imem_addr;
  logic [31:0] imem_data;
  logic        out_valid;
  logic [9:0]  out_pc_plus4;
  logic [31:0] out_instr;
  logic [2:0]  count;

  int n_checks = 0;
  int n_pass   = 0;

  if_prefetch_queue #(.DEPTH(4), .ADDR_W(10)) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .out_valid     (out_valid),
    .out_pc_plus4  (out_pc_plus4),
    .out_instr     (out_instr),
    .count         (count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [9:0] a);
    return {8'hE1, 14'h0, a};
  endfunction

  always_comb imem_data = rom(imem_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_addr = '0;

    // Reset state
    step();
    check("rst_imem_addr", 32'(imem_addr), 32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_pc4", 32'(out_pc_plus4), 32'h0);
    check("rst_instr", out_instr, 32'h0);
    check("rst_count", 32'(count), 32'h0);

    // Free run, no stall
    reset = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      check("run_pc4", 32'(out_pc_plus4), 32'(4 * k));
      check("run_instr", out_instr, rom(10'(4 * (k - 1))));
      check("run_count", 32'(count), 32'h1);
      check("run_imem_addr", 32'(imem_addr), 32'(4 * k));
    end

    // Stall from the first fetch for 6 cycles
    do_reset();
    stall = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      check("stall_count", 32'(count), 32'((k < 4) ? k : 4));
      check("stall_imem_addr", 32'(imem_addr), 32'((k < 4) ? 4 * k : 16));
      check("stall_head_pc4", 32'(out_pc_plus4), 32'h4);
    end

    // Release: full queue pops and pushes together, entries follow in order
    stall = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      check("drain_pc4", 32'(out_pc_plus4), 32'(4 + 4 * k));
      check("drain_instr", out_instr, rom(10'(4 * k)));
      check("drain_count", 32'(count), 32'h4);
    end

    // Redirect to 0x100 with 3 entries held under stall
    do_reset();
    stall = 1'b1;
    repeat (3) step();
    check("pre_redir_count", 32'(count), 32'h3);
    redirect = 1'b1; redirect_addr = 10'h100;
    check("redir_cycle_head", 32'(out_pc_plus4), 32'h4);
    step();
    redirect = 1'b0;
    check("redir_valid", 32'(out_valid), 32'h0);
    check("redir_count", 32'(count), 32'h0);
    check("redir_pc4_empty", 32'(out_pc_plus4), 32'h0);
    check("redir_imem_addr", 32'(imem_addr), 32'h100);
    step();
    check("redir_tgt_pc4", 32'(out_pc_plus4), 32'h104);
    check("redir_tgt_instr", out_instr, rom(10'h100));
    check("redir_tgt_count", 32'(count), 32'h1);

    // Redirect to unaligned 0x3FD, then wrap-around
    redirect = 1'b1; redirect_addr = 10'h3FD;
    step();
    redirect = 1'b0; stall = 1'b0;
    check("wrap_imem_addr", 32'(imem_addr), 32'h3FC);
    check("wrap_valid", 32'(out_valid), 32'h0);
    step();
    check("wrap_head_pc4", 32'(out_pc_plus4), 32'h0);
    check("wrap_head_instr", out_instr, rom(10'h3FC));
    check("wrap_valid2", 32'(out_valid), 32'h1);
    check("wrap_next_addr", 32'(imem_addr), 32'h0);
    step();
    check("wrap_after_pc4", 32'(out_pc_plus4), 32'h4);
    check("wrap_after_instr", out_instr, rom(10'h0));

    // Reset mid-stream on a full queue, with a concurrent redirect
    stall = 1'b1;
    repeat (4) step();
    check("full_count", 32'(count), 32'h4);
    reset = 1'b1; redirect = 1'b1; redirect_addr = 10'h200;
    step();
    check("mid_rst_valid", 32'(out_valid), 32'h0);
    check("mid_rst_pc4", 32'(out_pc_plus4), 32'h0);
    check("mid_rst_instr", out_instr, 32'h0);
    check("mid_rst_count", 32'(count), 32'h0);
    check("mid_rst_imem_addr", 32'(imem_addr), 32'h0);
    reset = 1'b0; redirect = 1'b0; stall = 1'b0;
    step();
    check("post_rst_pc4", 32'(out_pc_plus4), 32'h4);
    check("post_rst_imem_addr", 32'(imem_addr), 32'h4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
